regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (write, fpoint, rw, busW) between two producers. The integer pipeline writeback stage cannot stall and always wins. The multi-cycle FP unit hands results over with valid/ready into a small FIFO. The block drains that FIFO in idle write slots, requests pipeline bubbles when FP results starve, and reports pending FP writes to the hazard logic.

Parameters:
DEPTH, 4, FP result FIFO entries; power of two, >= 2
MAX_WAIT, 8, cycles the FIFO head may be blocked before a bubble is requested; >= 1

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
int_valid  input  1  integer writeback present this cycle; no ready, must be accepted
int_fpoint  input  2  fpoint code from writeback (0 int, 1 mtc1, 2 mfc1, 3 fp), passed through
int_rw  input  5  destination register
int_data  input  32  write data
fp_valid  input  1  FP unit result valid
fp_ready  output  1  FIFO can accept
fp_rw  input  5  FP destination register
fp_data  input  32  FP result
rf_write  output  1  register-file write strobe
rf_fpoint  output  2  register-file fpoint select
rf_rw  output  5  register-file write address
rf_busW  output  32  register-file write data
stall_req  output  1  ask pipeline for a writeback bubble next cycle
q_count  output  log2(DEPTH)+1  FIFO occupancy
chk_reg  input  5  register queried by hazard logic
chk_hit  output  1  chk_reg has a pending FP write (FIFO or output stage)

Behaviour:
- Reset: rf_write=0, rf_fpoint=0, rf_rw=0, rf_busW=0, stall_req=0, q_count=0, wait counter=0, FIFO flushed. Reset mid-operation discards queued FP results. All outputs are zero after that edge.
- fp_ready = (q_count != DEPTH), computed from registered count. A full FIFO refuses a push even in a cycle where it pops.
- Push on fp_valid && fp_ready: entry {fp_rw, fp_data} is stored at the tail. FP entries always drive fpoint=3.
- Output stage is registered. The selection made in cycle N appears on rf_* in cycle N+1, and rf_write is high for exactly one cycle per selection.
- Selection each cycle, in priority order:
  1) int_valid: load {int_fpoint, int_rw, int_data}.
  2) else if the FIFO is non-empty: pop the head and load {3, rw, data}.
  3) else: rf_write=0. The other rf_* outputs hold their last values.
- Integer latency is 1 cycle. FP latency is at least 2 cycles (push edge, then pop edge), FIFO order is preserved, and no entry is dropped or duplicated.
- Wait counter: increments (saturating at MAX_WAIT) each cycle the FIFO is non-empty and int_valid blocks the pop. It clears on any pop and whenever the FIFO is empty.
- stall_req is registered: next value = (wait counter reaches MAX_WAIT) || (q_count == DEPTH).
- Pipeline contract: int_valid is low in the cycle after stall_req=1. If int_valid is nonetheless high, integer still wins (no loss), the counter stays saturated and stall_req stays high.
- Simultaneous push and pop on a non-full FIFO leaves q_count unchanged. Pointers wrap modulo DEPTH.
- chk_hit is combinational: 1 if any occupied FIFO entry has rw==chk_reg, or rf_write=1 with rf_fpoint==3 and rf_rw==chk_reg. Register 0 is not special.

Optional Feature:
FP_BYPASS_EN
- Defined: when the FIFO is empty, int_valid=0 and fp_valid=1, the FP result goes straight to the output stage without being pushed. FP latency is 1 cycle, and q_count stays 0.
- Undefined: every FP result passes through the FIFO, so minimum FP latency is 2 cycles.

Test Plan:
- Reset then idle: rf_write=0, fp_ready=1, q_count=0, stall_req=0 for 5 cycles.
- int_valid with fpoint=0, rw=5, data=0xDEADBEEF -> next cycle rf_write=1, rf_fpoint=0, rf_rw=5, rf_busW=0xDEADBEEF; then rf_write=0.
- Single FP push rw=7, data=0x3F800000, no integer traffic:
  - without bypass: q_count=1 after the push edge, rf_write=1 with rf_fpoint=3, rf_rw=7 two cycles after the push.
  - with FP_BYPASS_EN: one cycle after the push.
- int_valid held high while pushing 4 FP results (DEPTH=4):
  - fp_ready drops at q_count=4 and stall_req=1.
  - drop int_valid: entries drain in order, one per cycle, with matching rw/data.
- One FP entry queued and int_valid high for 8 cycles (MAX_WAIT=8) -> stall_req=1 on the following cycle. A bubble pops the entry and stall_req returns to 0.
- FP entry rw=9 queued: chk_reg=9 gives chk_hit=1, chk_reg=10 gives 0. Assert reset mid-queue -> q_count=0, chk_hit=0, and no rf_write occurs for the flushed entry.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback/FP producers, the register-file write port
// and the hazard logic for regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          int_valid;
  logic [1:0]    int_fpoint;
  logic [4:0]    int_rw;
  logic [31:0]   int_data;
  logic          fp_valid;
  logic          fp_ready;
  logic [4:0]    fp_rw;
  logic [31:0]   fp_data;
  logic          rf_write;
  logic [1:0]    rf_fpoint;
  logic [4:0]    rf_rw;
  logic [31:0]   rf_busW;
  logic          stall_req;
  logic [CW-1:0] q_count;
  logic [4:0]    chk_reg;
  logic          chk_hit;

  modport slave (
    input  int_valid, int_fpoint, int_rw, int_data,
    input  fp_valid, fp_rw, fp_data,
    input  chk_reg,
    output fp_ready,
    output rf_write, rf_fpoint, rf_rw, rf_busW,
    output stall_req, q_count, chk_hit
  );

  modport master (
    output int_valid, int_fpoint, int_rw, int_data,
    output fp_valid, fp_rw, fp_data,
    output chk_reg,
    input  fp_ready,
    input  rf_write, rf_fpoint, rf_rw, rf_busW,
    input  stall_req, q_count, chk_hit
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: integer writeback always wins, FP results queue in a FIFO.
// Optional macro FP_BYPASS_EN lets an FP result skip the empty FIFO when the port is idle.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam int unsigned   WW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [WW-1:0] WaitMax = WW'(MAX_WAIT);
  localparam logic [1:0]    FpCode  = 2'd3;

  logic [4:0]    rw_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;
  logic          rf_write_q, rf_write_d;
  logic [1:0]    rf_fpoint_q, rf_fpoint_d;
  logic [4:0]    rf_rw_q, rf_rw_d;
  logic [31:0]   rf_busw_q, rf_busw_d;

  logic          empty, full, bypass, push, pop;
  logic          fifo_hit;
  logic [AW-1:0] scan_idx;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FullCnt);
`ifdef FP_BYPASS_EN
    bypass = empty && !wb.int_valid && wb.fp_valid;
`else
    bypass = 1'b0;
`endif
    // A full FIFO refuses the push even if it pops this cycle.
    push = wb.fp_valid && !full && !bypass;
    pop  = !wb.int_valid && !empty;
  end

  always_comb begin
    rf_write_d  = 1'b1;
    rf_fpoint_d = rf_fpoint_q;
    rf_rw_d     = rf_rw_q;
    rf_busw_d   = rf_busw_q;
    if (wb.int_valid) begin
      rf_fpoint_d = wb.int_fpoint;
      rf_rw_d     = wb.int_rw;
      rf_busw_d   = wb.int_data;
    end else if (pop) begin
      rf_fpoint_d = FpCode;
      rf_rw_d     = rw_mem_q[rd_ptr_q];
      rf_busw_d   = data_mem_q[rd_ptr_q];
    end else if (bypass) begin
      rf_fpoint_d = FpCode;
      rf_rw_d     = wb.fp_rw;
      rf_busw_d   = wb.fp_data;
    end else begin
      rf_write_d  = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // Non-empty without a pop means integer writeback blocked the head.
    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end
    stall_d = (wait_d == WaitMax) || (count_d == FullCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      stall_q     <= 1'b0;
      rf_write_q  <= 1'b0;
      rf_fpoint_q <= '0;
      rf_rw_q     <= '0;
      rf_busw_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      stall_q     <= stall_d;
      rf_write_q  <= rf_write_d;
      rf_fpoint_q <= rf_fpoint_d;
      rf_rw_q     <= rf_rw_d;
      rf_busw_q   <= rf_busw_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      rw_mem_q[wr_ptr_q]   <= wb.fp_rw;
      data_mem_q[wr_ptr_q] <= wb.fp_data;
    end
  end

  always_comb begin
    fifo_hit = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (rw_mem_q[scan_idx] == wb.chk_reg)) begin
        fifo_hit = 1'b1;
      end
    end
  end

  assign wb.fp_ready  = !full;
  assign wb.rf_write  = rf_write_q;
  assign wb.rf_fpoint = rf_fpoint_q;
  assign wb.rf_rw     = rf_rw_q;
  assign wb.rf_busW   = rf_busw_q;
  assign wb.stall_req = stall_q;
  assign wb.q_count   = count_q;
  assign wb.chk_hit   = fifo_hit ||
                        (rf_write_q && (rf_fpoint_q == FpCode) && (rf_rw_q == wb.chk_reg));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit [4:0]  qrw  [$];
  bit [31:0] qdat [$];
  bit        m_write;
  bit [1:0]  m_fp;
  bit [4:0]  m_rw;
  bit [31:0] m_data;
  int        m_wait;
  bit        m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input bit [4:0] r);
    bit h;
    h = m_write && (m_fp == 2'd3) && (m_rw == r);
    foreach (qrw[i]) if (qrw[i] == r) h = 1'b1;
    return h;
  endfunction

  task automatic check_all();
    chk("rf_write",  32'(bus.rf_write),  32'(m_write));
    chk("rf_fpoint", 32'(bus.rf_fpoint), 32'(m_fp));
    chk("rf_rw",     32'(bus.rf_rw),     32'(m_rw));
    chk("rf_busW",   bus.rf_busW,        m_data);
    chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
    chk("q_count",   32'(bus.q_count),   32'(qrw.size()));
    chk("fp_ready",  32'(bus.fp_ready),  32'(qrw.size() != DEPTH));
    chk("chk_hit",   32'(bus.chk_hit),   32'(model_hit(bus.chk_reg)));
  endtask

  task automatic model_step();
    bit byp;
    bit push_ok;
    byp = 1'b0;
    if (reset) begin
      qrw.delete();
      qdat.delete();
      m_write = 0; m_fp = 0; m_rw = 0; m_data = 0; m_wait = 0; m_stall = 0;
      return;
    end
`ifdef FP_BYPASS_EN
    byp = (qrw.size() == 0) && !bus.int_valid && bus.fp_valid;
`endif
    push_ok = bus.fp_valid && (qrw.size() < DEPTH) && !byp;
    if (bus.int_valid) begin
      m_write = 1; m_fp = bus.int_fpoint; m_rw = bus.int_rw; m_data = bus.int_data;
      if (qrw.size() > 0) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
    end else if (qrw.size() > 0) begin
      m_write = 1; m_fp = 3; m_rw = qrw.pop_front(); m_data = qdat.pop_front();
      m_wait = 0;
    end else if (byp) begin
      m_write = 1; m_fp = 3; m_rw = bus.fp_rw; m_data = bus.fp_data;
      m_wait = 0;
    end else begin
      m_write = 0;
      m_wait = 0;
    end
    if (push_ok) begin
      qrw.push_back(bus.fp_rw);
      qdat.push_back(bus.fp_data);
    end
    m_stall = (m_wait == MAX_WAIT) || (qrw.size() == DEPTH);
  endtask

  // Inputs are driven just after a negedge; outputs checked 1 time unit later.
  task automatic cycle(input bit do_chk);
    #1;
    if (do_chk) check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    bus.int_valid  = 0; bus.int_fpoint = 0; bus.int_rw = 0; bus.int_data = 0;
    bus.fp_valid   = 0; bus.fp_rw = 0; bus.fp_data = 0; bus.chk_reg = 0;
    m_write = 0; m_fp = 0; m_rw = 0; m_data = 0; m_wait = 0; m_stall = 0;
    @(negedge clk);
    cycle(1'b0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) cycle(1'b1);
    #1 chk("idle_ready", 32'(bus.fp_ready), 32'd1);

    // Integer write, latency 1
    bus.int_valid = 1; bus.int_fpoint = 0; bus.int_rw = 5; bus.int_data = 32'hDEADBEEF;
    cycle(1'b1);
    bus.int_valid = 0;
    #1;
    chk("int_write", 32'(bus.rf_write), 32'd1);
    chk("int_rw",    32'(bus.rf_rw),    32'd5);
    chk("int_data",  bus.rf_busW,       32'hDEADBEEF);
    cycle(1'b1);
    #1 chk("int_write_once", 32'(bus.rf_write), 32'd0);

    // Single FP result
    bus.fp_valid = 1; bus.fp_rw = 7; bus.fp_data = 32'h3F800000;
    cycle(1'b1);
    bus.fp_valid = 0;
`ifdef FP_BYPASS_EN
    #1;
    chk("fp_byp_write", 32'(bus.rf_write), 32'd1);
    chk("fp_byp_rw",    32'(bus.rf_rw),    32'd7);
    chk("fp_byp_cnt",   32'(bus.q_count),  32'd0);
`else
    #1;
    chk("fp_push_cnt",  32'(bus.q_count),  32'd1);
    chk("fp_push_nowr", 32'(bus.rf_write), 32'd0);
    cycle(1'b1);
    #1;
    chk("fp_write",  32'(bus.rf_write),  32'd1);
    chk("fp_fpoint", 32'(bus.rf_fpoint), 32'd3);
    chk("fp_rw",     32'(bus.rf_rw),     32'd7);
`endif
    cycle(1'b1);

    // Fill FIFO while integer traffic blocks the port
    bus.int_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.int_rw = 5'(i + 1); bus.int_data = $urandom;
      bus.fp_valid = 1; bus.fp_rw = 5'(10 + i); bus.fp_data = 32'hF000_0000 + 32'(i);
      cycle(1'b1);
    end
    bus.int_valid = 0; bus.fp_valid = 0;
    #1;
    chk("full_cnt",   32'(bus.q_count),   32'd4);
    chk("full_ready", 32'(bus.fp_ready),  32'd0);
    chk("full_stall", 32'(bus.stall_req), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1);
      #1;
      chk("drain_rw",   32'(bus.rf_rw), 32'(10 + i));
      chk("drain_data", bus.rf_busW,    32'hF000_0000 + 32'(i));
    end
    cycle(1'b1);

    // Starved head: MAX_WAIT blocked cycles raise stall_req
    bus.int_valid = 1; bus.int_rw = 1; bus.int_fpoint = 0;
    bus.fp_valid = 1; bus.fp_rw = 20; bus.fp_data = 32'h1234_5678;
    cycle(1'b1);
    bus.fp_valid = 0;
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      cycle(1'b1);
      #1 chk("wait_nostall", 32'(bus.stall_req), 32'd0);
    end
    cycle(1'b1);
    #1 chk("wait_stall", 32'(bus.stall_req), 32'd1);
    bus.int_valid = 0;
    cycle(1'b1);
    #1;
    chk("bubble_rw",    32'(bus.rf_rw),     32'd20);
    chk("bubble_stall", 32'(bus.stall_req), 32'd0);
    cycle(1'b1);

    // Hazard query, then reset flushes the queue
    bus.int_valid = 1; bus.int_rw = 2; bus.int_fpoint = 0;
    bus.fp_valid = 1; bus.fp_rw = 9; bus.fp_data = 32'hCAFE_0009;
    cycle(1'b1);
    bus.fp_valid = 0;
    bus.chk_reg = 9;
    #1 chk("hit_9", 32'(bus.chk_hit), 32'd1);
    bus.chk_reg = 10;
    #1 chk("hit_10", 32'(bus.chk_hit), 32'd0);
    bus.chk_reg = 9;
    bus.int_valid = 0;
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    #1;
    chk("rst_cnt", 32'(bus.q_count),  32'd0);
    chk("rst_hit", 32'(bus.chk_hit),  32'd0);
    chk("rst_wr",  32'(bus.rf_write), 32'd0);
    cycle(1'b1);
    #1 chk("flushed_nowr", 32'(bus.rf_write), 32'd0);

    // Random traffic honouring the stall contract
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.int_valid  = !m_stall && ($urandom_range(0, 99) < 45);
      bus.int_fpoint = 2'($urandom);
      bus.int_rw     = 5'($urandom_range(0, 7));
      bus.int_data   = $urandom;
      bus.fp_valid   = ($urandom_range(0, 99) < 50);
      bus.fp_rw      = 5'($urandom_range(0, 7));
      bus.fp_data    = $urandom;
      bus.chk_reg    = 5'($urandom_range(0, 7));
      cycle(1'b1);
    end
    reset = 1'b0;
    bus.int_valid = 0; bus.fp_valid = 0;
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
